// File: rtl/multicycle_divider_pkg.sv
// Shared CPU definitions for the EXE-stage divider: state encodings and widths.
package cpu_defs;

   localparam int DATA_WIDTH = 32;

   typedef enum logic [1:0] {
      DIV_STATE_IDLE = 2'd0,
      DIV_STATE_CALC = 2'd1,
      DIV_STATE_DONE = 2'd2
   } div_state_e;

   // Counter must hold the value WIDTH itself, hence the extra bit.
   function automatic int div_cnt_width(input int width);
      return $clog2(width) + 1;
   endfunction

   localparam int DIV_CNT_WIDTH = div_cnt_width(DATA_WIDTH);

endpackage

// File: rtl/multicycle_divider_restore_step.sv
// One radix-2 restoring step: shift in the next dividend bit, trial-subtract, select.
module div_restore_step
   import cpu_defs::*;
#(
   parameter int WIDTH = DATA_WIDTH
) (
   input  logic [WIDTH-1:0] rem_in,
   input  logic             dividend_bit,
   input  logic [WIDTH-1:0] divisor_mag,
   output logic [WIDTH-1:0] rem_out,
   output logic             quotient_bit
);

   logic [WIDTH:0] shifted;
   logic [WIDTH:0] diff;

   assign shifted = {rem_in, dividend_bit};
   // The extra top bit acts as the borrow: set means the trial went negative.
   assign diff         = shifted - {1'b0, divisor_mag};
   assign quotient_bit = ~diff[WIDTH];
   assign rem_out      = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];

endmodule

// File: rtl/multicycle_divider.sv
// Iterative restoring divider for MIPS DIV/DIVU: WIDTH busy cycles, then a one-cycle done pulse.
module multicycle_divider
   import cpu_defs::*;
#(
   parameter int WIDTH = DATA_WIDTH
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             i_start,
   input  logic             i_signed,
   input  logic [WIDTH-1:0] i_dividend,
   input  logic [WIDTH-1:0] i_divisor,
   input  logic             i_cancel,
   output logic             o_busy,
   output logic             o_done,
   output logic [WIDTH-1:0] o_quotient,
   output logic [WIDTH-1:0] o_remainder,
   output logic             o_div_zero
);

   localparam int CNT_W = div_cnt_width(WIDTH);

   div_state_e       state, state_next;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] rem_q;
   logic [WIDTH-1:0] dvd_q;
   logic [WIDTH-1:0] dvs_q;
   logic             q_neg;
   logic             r_neg;

   logic             accept;
   logic             finish;

   logic             dividend_neg;
   logic             divisor_neg;
   logic [WIDTH-1:0] dividend_mag;
   logic [WIDTH-1:0] divisor_mag;

   logic [WIDTH-1:0] step_rem;
   logic             step_qbit;
   logic [WIDTH-1:0] quot_mag;
   logic [WIDTH-1:0] quot_final;
   logic [WIDTH-1:0] rem_final;

   // Negating the most negative value wraps to itself, which is its correct unsigned magnitude.
   assign dividend_neg = i_signed & i_dividend[WIDTH-1];
   assign divisor_neg  = i_signed & i_divisor[WIDTH-1];
   assign dividend_mag = dividend_neg ? -i_dividend : i_dividend;
   assign divisor_mag  = divisor_neg  ? -i_divisor  : i_divisor;

   div_restore_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .rem_in       (rem_q),
      .dividend_bit (dvd_q[WIDTH-1]),
      .divisor_mag  (dvs_q),
      .rem_out      (step_rem),
      .quotient_bit (step_qbit)
   );

   // The dividend register doubles as the quotient shift register.
   assign quot_mag   = {dvd_q[WIDTH-2:0], step_qbit};
   assign quot_final = q_neg ? -quot_mag : quot_mag;
   assign rem_final  = r_neg ? -step_rem : step_rem;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state <= DIV_STATE_IDLE;
      end else begin
         // NOTE: non-blocking so every register samples pre-edge values regardless of statement order.
         state <= state_next;
      end
   end

   always_comb begin
      // NOTE: defaults first so every path assigns each signal and no latch is inferred.
      state_next = state;
      accept     = 1'b0;
      finish     = 1'b0;
      case (state)
         DIV_STATE_IDLE: begin
            if (i_start) begin
               accept     = 1'b1;
               state_next = DIV_STATE_CALC;
            end
         end
         DIV_STATE_CALC: begin
            if (cnt == CNT_W'(1)) begin
               finish     = 1'b1;
               state_next = DIV_STATE_DONE;
            end
         end
         DIV_STATE_DONE: begin
            if (i_start) begin
               accept     = 1'b1;
               state_next = DIV_STATE_CALC;
            end else begin
               state_next = DIV_STATE_IDLE;
            end
         end
         default: state_next = DIV_STATE_IDLE;
      endcase
      // A flush outranks both a new launch and a completing operation.
      if (i_cancel) begin
         state_next = DIV_STATE_IDLE;
         accept     = 1'b0;
         finish     = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt         <= '0;
         rem_q       <= '0;
         dvd_q       <= '0;
         dvs_q       <= '0;
         q_neg       <= 1'b0;
         r_neg       <= 1'b0;
         o_busy      <= 1'b0;
         o_done      <= 1'b0;
         o_quotient  <= '0;
         o_remainder <= '0;
         o_div_zero  <= 1'b0;
      end else begin
         o_busy <= (state_next == DIV_STATE_CALC);
         o_done <= finish;
         if (accept) begin
            cnt   <= CNT_W'(WIDTH);
            rem_q <= '0;
            dvd_q <= dividend_mag;
            dvs_q <= divisor_mag;
            q_neg <= dividend_neg ^ divisor_neg;
            r_neg <= dividend_neg;
         end else if (state == DIV_STATE_CALC && !i_cancel) begin
            cnt   <= cnt - 1'b1;
            rem_q <= step_rem;
            dvd_q <= quot_mag;
         end
         if (finish) begin
            o_quotient  <= quot_final;
            o_remainder <= rem_final;
            o_div_zero  <= (dvs_q == '0);
         end
      end
   end

endmodule

// File: tb/tb_multicycle_divider.sv
// Directed bench for multicycle_divider: vector table plus timing, cancel, restart and reset sequences.
module tb_multicycle_divider;

   localparam int W = 32;

   logic          clk;
   logic          resetn;
   logic          i_start;
   logic          i_signed;
   logic [W-1:0]  i_dividend;
   logic [W-1:0]  i_divisor;
   logic          i_cancel;
   logic          o_busy;
   logic          o_done;
   logic [W-1:0]  o_quotient;
   logic [W-1:0]  o_remainder;
   logic          o_div_zero;

   int total = 0;
   int bad   = 0;

   typedef struct {
      string        name;
      logic         sgn;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         dz;
   } vec_t;

   vec_t vecs[12];

   multicycle_divider #(.WIDTH(W)) dut (
      .clk         (clk),
      .resetn      (resetn),
      .i_start     (i_start),
      .i_signed    (i_signed),
      .i_dividend  (i_dividend),
      .i_divisor   (i_divisor),
      .i_cancel    (i_cancel),
      .o_busy      (o_busy),
      .o_done      (o_done),
      .o_quotient  (o_quotient),
      .o_remainder (o_remainder),
      .o_div_zero  (o_div_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic step_cycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Leaves the bench 1 time unit after the edge that sampled the start.
   task automatic start_op(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
      @(negedge clk);
      i_signed   = s;
      i_dividend = a;
      i_divisor  = b;
      i_start    = 1'b1;
      @(posedge clk);
      #1;
      i_start = 1'b0;
   endtask

   task automatic wait_done(output int lat, output int busy_cycles);
      lat         = 0;
      busy_cycles = 0;
      while (o_done !== 1'b1 && lat < 100) begin
         if (o_busy === 1'b1) busy_cycles++;
         @(posedge clk);
         #1;
         lat++;
      end
      if (o_done !== 1'b1) check("done_timeout", 32'(o_done), 32'd1);
   endtask

   initial begin
      int lat;
      int bc;

      vecs[0]  = '{"divu_100_7",     1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0};
      vecs[1]  = '{"div_m7_2",       1'b1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF,   1'b0};
      vecs[2]  = '{"div_7_m2",       1'b1, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1,          1'b0};
      vecs[3]  = '{"divu_5_0",       1'b0, 32'd5,          32'd0,          32'hFFFFFFFF,   32'd5,          1'b1};
      vecs[4]  = '{"div_ovf",        1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          1'b0};
      vecs[5]  = '{"div_m7_0",       1'b1, 32'hFFFFFFF9,   32'd0,          32'd1,          32'hFFFFFFF9,   1'b1};
      vecs[6]  = '{"divu_max_1",     1'b0, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0,          1'b0};
      vecs[7]  = '{"divu_min_3",     1'b0, 32'h80000000,   32'd3,          32'h2AAAAAAA,   32'd2,          1'b0};
      vecs[8]  = '{"div_min_2",      1'b1, 32'h80000000,   32'd2,          32'hC0000000,   32'd0,          1'b0};
      vecs[9]  = '{"divu_7_big",     1'b0, 32'd7,          32'hFFFFFFFE,   32'd0,          32'd7,          1'b0};
      vecs[10] = '{"div_m100_m7",    1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9,   32'd14,         32'hFFFFFFFE,   1'b0};
      vecs[11] = '{"divu_12345678",  1'b0, 32'd12345678,   32'd1000,       32'd12345,      32'd678,        1'b0};

      resetn     = 1'b0;
      i_start    = 1'b0;
      i_signed   = 1'b0;
      i_dividend = '0;
      i_divisor  = '0;
      i_cancel   = 1'b0;
      #12;
      check("reset_busy", 32'(o_busy), 32'd0);
      check("reset_done", 32'(o_done), 32'd0);
      check("reset_q",    o_quotient,  32'd0);
      check("reset_r",    o_remainder, 32'd0);
      check("reset_dz",   32'(o_div_zero), 32'd0);
      @(negedge clk);
      resetn = 1'b1;
      step_cycles(2);

      // Timing of the first operation: 32 busy cycles then a single done cycle.
      start_op(1'b0, 32'd100, 32'd7);
      check("t1_busy", 32'(o_busy), 32'd1);
      wait_done(lat, bc);
      check("t_latency",    32'(lat), 32'd32);
      check("t_busy_count", 32'(bc),  32'd32);
      check("t_busy_at_done", 32'(o_busy), 32'd0);
      check("t_q",  o_quotient,  32'd14);
      check("t_r",  o_remainder, 32'd2);
      check("t_dz", 32'(o_div_zero), 32'd0);
      step_cycles(1);
      check("t_done_pulse", 32'(o_done), 32'd0);
      check("t_q_held", o_quotient, 32'd14);

      for (int i = 0; i < 12; i++) begin
         start_op(vecs[i].sgn, vecs[i].a, vecs[i].b);
         wait_done(lat, bc);
         check({vecs[i].name, "_lat"}, 32'(lat), 32'd32);
         check({vecs[i].name, "_q"},   o_quotient,  vecs[i].q);
         check({vecs[i].name, "_r"},   o_remainder, vecs[i].r);
         check({vecs[i].name, "_dz"},  32'(o_div_zero), 32'(vecs[i].dz));
      end

      // Cancel mid-operation with 14/2 held from a completed 100/7.
      start_op(1'b0, 32'd100, 32'd7);
      wait_done(lat, bc);
      check("c_prior_q", o_quotient, 32'd14);
      start_op(1'b0, 32'd100, 32'd7);
      step_cycles(9);
      i_cancel = 1'b1;
      step_cycles(1);
      i_cancel = 1'b0;
      check("c_busy_t11", 32'(o_busy), 32'd0);
      check("c_done_t11", 32'(o_done), 32'd0);
      check("c_q_held",   o_quotient,  32'd14);
      check("c_r_held",   o_remainder, 32'd2);
      step_cycles(1);
      check("c_done_t12", 32'(o_done), 32'd0);
      start_op(1'b0, 32'd100, 32'd3);
      wait_done(lat, bc);
      check("c_new_lat", 32'(lat), 32'd32);
      check("c_new_q",   o_quotient,  32'd33);
      check("c_new_r",   o_remainder, 32'd1);

      // Cancel on the completing edge suppresses done and keeps old results.
      start_op(1'b0, 32'd9, 32'd2);
      step_cycles(31);
      i_cancel = 1'b1;
      step_cycles(1);
      i_cancel = 1'b0;
      check("cf_done", 32'(o_done), 32'd0);
      check("cf_busy", 32'(o_busy), 32'd0);
      check("cf_q",    o_quotient, 32'd33);

      // Start together with cancel is refused.
      @(negedge clk);
      i_start  = 1'b1;
      i_cancel = 1'b1;
      step_cycles(1);
      i_start  = 1'b0;
      i_cancel = 1'b0;
      check("cs_busy", 32'(o_busy), 32'd0);

      // A start pulse during CALC is ignored.
      start_op(1'b0, 32'd1000, 32'd10);
      step_cycles(4);
      i_start    = 1'b1;
      i_dividend = 32'd9;
      i_divisor  = 32'd2;
      step_cycles(1);
      i_start = 1'b0;
      wait_done(lat, bc);
      check("rs_lat", 32'(lat + 5), 32'd32);
      check("rs_q",   o_quotient,  32'd100);
      check("rs_r",   o_remainder, 32'd0);

      // Start held high through DONE is accepted back to back.
      @(negedge clk);
      i_signed   = 1'b0;
      i_dividend = 32'd50;
      i_divisor  = 32'd5;
      i_start    = 1'b1;
      step_cycles(1);
      i_dividend = 32'd60;
      i_divisor  = 32'd7;
      wait_done(lat, bc);
      check("bb_lat1", 32'(lat), 32'd32);
      check("bb_q1",   o_quotient, 32'd10);
      step_cycles(1);
      check("bb_busy_t34", 32'(o_busy), 32'd1);
      check("bb_done_t34", 32'(o_done), 32'd0);
      i_start = 1'b0;
      wait_done(lat, bc);
      check("bb_lat2", 32'(lat), 32'd32);
      check("bb_q2",   o_quotient,  32'd8);
      check("bb_r2",   o_remainder, 32'd4);

      // Asynchronous reset between edges mid-operation.
      start_op(1'b1, 32'hFFFFFFF9, 32'd2);
      step_cycles(14);
      #3;
      resetn = 1'b0;
      #1;
      check("ar_busy", 32'(o_busy), 32'd0);
      check("ar_done", 32'(o_done), 32'd0);
      check("ar_q",    o_quotient,  32'd0);
      check("ar_r",    o_remainder, 32'd0);
      check("ar_dz",   32'(o_div_zero), 32'd0);
      @(negedge clk);
      resetn = 1'b1;
      step_cycles(3);
      check("ar_idle_busy", 32'(o_busy), 32'd0);
      check("ar_idle_q",    o_quotient,  32'd0);
      start_op(1'b1, 32'd7, 32'hFFFFFFFE);
      wait_done(lat, bc);
      check("ar_after_q", o_quotient,  32'hFFFFFFFD);
      check("ar_after_r", o_remainder, 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
